// File: rtl/pipe_pkg.sv
// pipe_pkg: shared definitions for the inter-stage pipeline registers.
//   NOP_INSTR     - encoding of the canonical no-op (addi x0, x0, 0).
//   skid_state_t  - occupancy of a pipe_stage_skid instance.
//   qXqY_t        - payload layout for each pipeline boundary.
//                   Callers size the stage with DATA_W = $bits(qXqY_t).
package pipe_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,   // no entries held
        ONE   = 2'd1,   // main entry only
        TWO   = 2'd2    // main plus skid entry
    } skid_state_t;

    // Fetch -> decode
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } q1q2_t;

    // Decode -> execute
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [4:0]  rd;
        logic        rd_we;
    } q2q3_t;

    // Execute -> memory
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] alu_res;
        logic [31:0] store_val;
        logic [4:0]  rd;
        logic        rd_we;
        logic        mem_rd;
        logic        mem_wr;
    } q3q4_t;

    // Memory -> writeback
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] wb_val;
        logic [4:0]  rd;
        logic        rd_we;
    } q4q5_t;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at all-ones instead of wrapping.
//   i_clk    - clock, rising edge
//   i_rst_n  - asynchronous active-low reset, clears the count
//   i_inc    - increment request for this cycle
//   o_count  - current count (registered)
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // NOTE: combinational blocks use blocking '=' and assign a default first,
    // so no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        count_d = count_q;
        if (i_inc && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    // NOTE: clocked state uses non-blocking '<=' so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_count = count_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: valid/ready pipeline register with a 2-entry skid buffer.
//   i_clk, i_rst_n  - clock (rising edge), asynchronous active-low reset
//   i_valid/o_ready - upstream handshake; o_ready depends only on flops
//   i_data          - upstream payload, sampled only when accepted
//   o_valid/i_ready - downstream handshake
//   o_data          - downstream payload, driven straight from the main entry
//   i_flush         - synchronous discard of every held entry
// Optional build macro PIPE_STAGE_STATS_EN adds:
//   o_stall_cycles  - cycles with o_valid & ~i_ready (saturating)
//   o_flush_drops   - flushes that discarded a valid entry (saturating)
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int                DATA_W     = 64,
    parameter logic [DATA_W-1:0] BUBBLE_VAL = {DATA_W{1'b0}}
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    input  logic              i_flush
`ifdef PIPE_STAGE_STATS_EN
    ,
    output logic [31:0]       o_stall_cycles,
    output logic [15:0]       o_flush_drops
`endif
);

    skid_state_t       state_q, state_d;
    logic [DATA_W-1:0] main_q,  main_d;
    logic [DATA_W-1:0] skid_q,  skid_d;

    logic accept;
    logic drain;

    // Both handshake outputs decode the registered state, so a downstream
    // stall reaches upstream one cycle later through the skid entry rather
    // than through a combinational i_ready -> o_ready path.
    assign o_ready = (state_q != TWO);
    assign o_valid = (state_q != EMPTY);
    assign o_data  = main_q;

    assign accept  = i_valid & o_ready;
    assign drain   = o_valid & i_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        if (i_flush) begin
            // Flush wins over a same-cycle accept. A same-cycle drain has
            // already been sampled downstream, so clearing is all it needs.
            state_d = EMPTY;
            main_d  = BUBBLE_VAL;
            skid_d  = BUBBLE_VAL;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d = ONE;
                        main_d  = i_data;
                    end
                end
                ONE: begin
                    if (accept && drain) begin
                        main_d = i_data;
                    end else if (accept) begin
                        // Downstream stalled: park the new beat in skid so
                        // main (and o_data) stays stable.
                        state_d = TWO;
                        skid_d  = i_data;
                    end else if (drain) begin
                        state_d = EMPTY;
                        main_d  = BUBBLE_VAL;
                    end
                end
                TWO: begin
                    if (drain) begin
                        state_d = ONE;
                        main_d  = skid_q;
                        skid_d  = BUBBLE_VAL;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    main_d  = BUBBLE_VAL;
                    skid_d  = BUBBLE_VAL;
                end
            endcase
        end
    end

    // NOTE: the payload registers are reset too, not just the state, because
    // o_data must read BUBBLE_VAL during and straight after reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= EMPTY;
            main_q  <= BUBBLE_VAL;
            skid_q  <= BUBBLE_VAL;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

`ifdef PIPE_STAGE_STATS_EN
    logic stall_inc;
    logic drop_inc;

    assign stall_inc = o_valid & ~i_ready;
    // Only flushes that actually threw something away are counted.
    assign drop_inc  = i_flush & (state_q != EMPTY);

    sat_counter #(.WIDTH(32)) u_stall_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_inc   (stall_inc),
        .o_count (o_stall_cycles)
    );

    sat_counter #(.WIDTH(16)) u_drop_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_inc   (drop_inc),
        .o_count (o_flush_drops)
    );
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: directed self-checking bench for pipe_stage_skid
// (DATA_W=64, BUBBLE_VAL=0). Stats checks are built when PIPE_STAGE_STATS_EN
// is defined.
module tb_pipe_stage_skid;

    localparam int          DW  = 64;
    localparam logic [DW-1:0] BUB = '0;

    logic          clk;
    logic          rst_n;
    logic          i_valid;
    logic          o_ready;
    logic [DW-1:0] i_data;
    logic          o_valid;
    logic          i_ready;
    logic [DW-1:0] o_data;
    logic          i_flush;
`ifdef PIPE_STAGE_STATS_EN
    logic [31:0]   o_stall_cycles;
    logic [15:0]   o_flush_drops;
`endif

    int checks   = 0;
    int failures = 0;

    pipe_stage_skid #(.DATA_W(DW), .BUBBLE_VAL(BUB)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_valid        (i_valid),
        .o_ready        (o_ready),
        .i_data         (i_data),
        .o_valid        (o_valid),
        .i_ready        (i_ready),
        .o_data         (o_data),
        .i_flush        (i_flush)
`ifdef PIPE_STAGE_STATS_EN
        ,
        .o_stall_cycles (o_stall_cycles),
        .o_flush_drops  (o_flush_drops)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; inputs change and outputs are sampled 1ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b0; i_flush = 1'b0; i_data = '0;
        step();
        checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", o_valid); end
        checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", o_ready); end
        checks++; if (o_data !== BUB) begin failures++; $display("FAIL reset_data got=%h exp=%h", o_data, BUB); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        i_valid = 1'b1; i_data = 64'hA5; i_ready = 1'b1;
        checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL single_pre_valid got=%b exp=0", o_valid); end
        step();
        i_valid = 1'b0;
        checks++; if (o_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", o_valid); end
        checks++; if (o_data !== 64'hA5) begin failures++; $display("FAIL single_data got=%h exp=a5", o_data); end
        checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL single_ready got=%b exp=1", o_ready); end
        step();
        checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL single_drain_valid got=%b exp=0", o_valid); end
        checks++; if (o_data !== BUB) begin failures++; $display("FAIL single_drain_data got=%h exp=%h", o_data, BUB); end
    endtask

    task automatic test_stream();
        logic [DW-1:0] vals [3];
        vals[0] = 64'h1; vals[1] = 64'h2; vals[2] = 64'h3;
        i_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            i_valid = 1'b1; i_data = vals[k];
            step();
            checks++; if (o_valid !== 1'b1 || o_data !== vals[k]) begin
                failures++; $display("FAIL stream_%0d got=%b/%h exp=1/%h", k, o_valid, o_data, vals[k]);
            end
        end
        i_valid = 1'b0;
        step();
        checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL stream_end_valid got=%b exp=0", o_valid); end
    endtask

    task automatic test_backpressure();
        i_ready = 1'b0;
        i_valid = 1'b1; i_data = 64'h10;
        step();
        checks++; if (o_data !== 64'h10 || o_ready !== 1'b1) begin
            failures++; $display("FAIL bp_one got=%h/%b exp=10/1", o_data, o_ready);
        end
        i_data = 64'h11;
        step();
        checks++; if (o_ready !== 1'b0) begin failures++; $display("FAIL bp_two_ready got=%b exp=0", o_ready); end
        checks++; if (o_data !== 64'h10) begin failures++; $display("FAIL bp_two_data got=%h exp=10", o_data); end
        i_data = 64'h12;   // held upstream: o_ready is low
        step();
        checks++; if (o_data !== 64'h10 || o_valid !== 1'b1 || o_ready !== 1'b0) begin
            failures++; $display("FAIL bp_hold got=%h/%b/%b exp=10/1/0", o_data, o_valid, o_ready);
        end
        i_ready = 1'b1;    // 0x10 drains; 0x12 still refused this edge
        step();
        checks++; if (o_data !== 64'h11 || o_ready !== 1'b1) begin
            failures++; $display("FAIL bp_out11 got=%h/%b exp=11/1", o_data, o_ready);
        end
        step();            // 0x11 drains while 0x12 is accepted
        i_valid = 1'b0;
        checks++; if (o_data !== 64'h12 || o_valid !== 1'b1) begin
            failures++; $display("FAIL bp_out12 got=%h/%b exp=12/1", o_data, o_valid);
        end
        step();
        checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL bp_empty got=%b exp=0", o_valid); end
    endtask

    task automatic test_flush();
        // Fill to TWO, then flush with a new payload offered.
        i_ready = 1'b0; i_valid = 1'b1; i_data = 64'h20;
        step();
        i_data = 64'h21;
        step();
        i_flush = 1'b1; i_data = 64'h55;
        step();
        i_flush = 1'b0; i_valid = 1'b0;
        checks++; if (o_valid !== 1'b0 || o_data !== BUB || o_ready !== 1'b1) begin
            failures++; $display("FAIL flush_two got=%b/%h/%b exp=0/%h/1", o_valid, o_data, o_ready, BUB);
        end
        step();
        checks++; if (o_valid !== 1'b0 || o_data === 64'h55) begin
            failures++; $display("FAIL flush_two_after got=%b/%h exp=0/%h", o_valid, o_data, BUB);
        end
        // ONE state: flush beats an accept that o_ready would allow.
        i_valid = 1'b1; i_data = 64'h30;
        step();
        i_flush = 1'b1; i_data = 64'h55;
        step();
        i_flush = 1'b0; i_valid = 1'b0;
        checks++; if (o_valid !== 1'b0 || o_data !== BUB) begin
            failures++; $display("FAIL flush_one got=%b/%h exp=0/%h", o_valid, o_data, BUB);
        end
    endtask

    task automatic test_x_data();
        i_valid = 1'b0; i_ready = 1'b1; i_data = 'x;
        step();
        step();
        checks++; if (o_valid !== 1'b0 || o_data !== BUB) begin
            failures++; $display("FAIL x_idle got=%b/%h exp=0/%h", o_valid, o_data, BUB);
        end
        i_data = '0;
    endtask

    task automatic test_async_reset();
        i_ready = 1'b0; i_valid = 1'b1; i_data = 64'h40;
        step();
        i_data = 64'h41;
        step();
        i_valid = 1'b0;
        #2 rst_n = 1'b0;   // mid-cycle, no clock edge involved
        #1;
        checks++; if (o_valid !== 1'b0 || o_data !== BUB || o_ready !== 1'b1) begin
            failures++; $display("FAIL async_reset got=%b/%h/%b exp=0/%h/1", o_valid, o_data, o_ready, BUB);
        end
        rst_n = 1'b1;
        i_valid = 1'b1; i_data = 64'h77; i_ready = 1'b1;
        step();
        i_valid = 1'b0;
        checks++; if (o_valid !== 1'b1 || o_data !== 64'h77) begin
            failures++; $display("FAIL post_reset_accept got=%b/%h exp=1/77", o_valid, o_data);
        end
        step();
    endtask

`ifdef PIPE_STAGE_STATS_EN
    task automatic test_stats();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        checks++; if (o_stall_cycles !== 32'd0 || o_flush_drops !== 16'd0) begin
            failures++; $display("FAIL stats_reset got=%0d/%0d exp=0/0", o_stall_cycles, o_flush_drops);
        end
        i_ready = 1'b0; i_valid = 1'b1; i_data = 64'h60;
        step();
        i_valid = 1'b0;
        for (int k = 0; k < 5; k++) step();
        checks++; if (o_stall_cycles !== 32'd5) begin
            failures++; $display("FAIL stats_stall got=%0d exp=5", o_stall_cycles);
        end
        i_flush = 1'b1;    // this edge is also a stall cycle
        step();
        checks++; if (o_flush_drops !== 16'd1 || o_stall_cycles !== 32'd6) begin
            failures++; $display("FAIL stats_drop got=%0d/%0d exp=1/6", o_flush_drops, o_stall_cycles);
        end
        step();            // flush while EMPTY
        i_flush = 1'b0;
        checks++; if (o_flush_drops !== 16'd1 || o_stall_cycles !== 32'd6) begin
            failures++; $display("FAIL stats_empty_flush got=%0d/%0d exp=1/6", o_flush_drops, o_stall_cycles);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_stream();
        test_backpressure();
        test_flush();
        test_x_data();
        test_async_reset();
`ifdef PIPE_STAGE_STATS_EN
        test_stats();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Next-generation inter-stage pipeline register for the CPU pipeline (Q1..Q5 boundaries).
- Replaces fixed-field free-running registers with one parametrised payload register plus a valid/ready handshake, a 2-entry skid buffer, flush and bubble injection.
- Stages pack their fields into one payload vector; a stall from downstream propagates upstream without combinational ready paths.

Parameters:
- DATA_W, 64: payload width in bits, legal range 1..1024.
- BUBBLE_VAL, {DATA_W{1'b0}}: payload value on reset, flush and empty. Stages that carry an instruction set the instruction slice to 32'h00000013 (NOP).

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst_n  input  1  reset, asynchronous, active-low.
- i_valid  input  1  upstream payload valid.
- o_ready  output  1  stage can accept; registered.
- i_data  input  DATA_W  upstream payload.
- o_valid  output  1  downstream payload valid.
- i_ready  input  1  downstream accepts.
- o_data  output  DATA_W  downstream payload; registered.
- i_flush  input  1  synchronous kill of all held entries (branch/trap).

Behaviour:
- Reset: the clock is i_clk. Reset is asynchronous and active-low on i_rst_n. During reset, o_valid=0, o_ready=1, o_data=BUBBLE_VAL, main and skid entries are empty and skid data=BUBBLE_VAL.
- Storage: main entry (drives o_data/o_valid) and skid entry.
- State: EMPTY (no entries), ONE (main only), TWO (main+skid).
- Handshakes: accept = i_valid & o_ready; drain = o_valid & i_ready.
- EMPTY: accept -> ONE, main<=i_data. Latency is 1 cycle, i_data to o_data.
- ONE:
  - accept & drain -> ONE, main<=i_data.
  - accept & ~drain -> TWO, skid<=i_data.
  - drain & ~accept -> EMPTY, main<=BUBBLE_VAL.
  - neither -> hold.
- TWO: o_ready=0, so no accept. On drain -> ONE, main<=skid, skid<=BUBBLE_VAL. Otherwise hold.
- o_ready = (state != TWO), taken from the registered state. There is no i_ready->o_ready combinational path.
- Full throughput: 1 transfer per cycle when i_ready is held high.
- Flush:
  - i_flush=1 at an edge -> next state EMPTY, o_valid=0, o_data=BUBBLE_VAL, o_ready=1.
  - Flush overrides a simultaneous accept: that payload is dropped.
  - A simultaneous drain still completes, because the downstream sampled it this cycle.
- o_valid is never asserted with o_data != the held entry. o_data changes only on drain, on a load into EMPTY, or on flush.
- i_data is ignored when ~i_valid. X on i_data while ~i_valid must not propagate.
- Reset mid-operation: all entries are discarded asynchronously. There is no partial transfer.
- Stable-valid rule: while o_valid=1 and i_ready=0, o_data and o_valid hold.

Optional Feature:
- Macro: PIPE_STAGE_STATS_EN.
- Defined:
  - Adds output o_stall_cycles [31:0]: counts cycles where o_valid & ~i_ready. It saturates at 32'hFFFFFFFF, reset value is 0, and it is not cleared by flush.
  - Adds output o_flush_drops [15:0]: counts flushes that discarded at least one valid entry. It saturates at 16'hFFFF and its reset value is 0.
- Undefined: neither port nor counter exists. Handshake and data behaviour is identical in both builds.

Decomposition:
- Package pipe_pkg:
  - NOP_INSTR=32'h00000013.
  - Enum typedef skid_state_t {EMPTY, ONE, TWO}.
  - Packed-struct typedefs per boundary (q1q2_t..q4q5_t), used by callers as DATA_W=$bits(qXqY_t).
- Sub-module sat_counter (parametrised width, inc, saturate, async reset). It is instantiated only under PIPE_STAGE_STATS_EN.

Test Plan:
- Reset release, then i_valid=1, i_data=64'hA5, i_ready=1 -> o_valid=1 and o_data=64'hA5 exactly one cycle later; o_ready stays 1.
- Streaming 0x1,0x2,0x3 with i_ready=1 -> o_data is 0x1,0x2,0x3 on consecutive cycles; no bubble, no duplicate.
- i_ready=0 while sending 0x10,0x11,0x12:
  - 0x10 goes to main and 0x11 to skid, then o_ready=0 and 0x12 is held upstream.
  - Raise i_ready -> outputs are 0x10,0x11,0x12 in order.
- TWO state plus i_flush=1 and i_valid=1 (0x55) in the same cycle -> next cycle o_valid=0, o_data=BUBBLE_VAL, o_ready=1; 0x55 never appears.
- i_rst_n asserted low mid-cycle while in TWO -> o_valid=0 and o_data=BUBBLE_VAL immediately, without waiting for a clock edge; after release the stage accepts on the first cycle.
- STATS build: hold i_ready=0 for 5 cycles with main valid -> o_stall_cycles=5; a flush with entries held -> o_flush_drops=1; a flush while EMPTY -> no increment.
